// File: rtl/rr_bus.sv
// Multi-host to multi-device bus: a combinational arbiter (fixed priority or round-robin),
// an address decoder, and a one-cycle registered response path back to the granted host.
module rr_bus #(
    parameter int unsigned NrHosts      = 2,
    parameter int unsigned NrDevices    = 4,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned ArbMode      = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrHosts-1:0]                  host_req_i,
    output logic [NrHosts-1:0]                  host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                  host_we_i,
    input  logic [NrHosts*(DataWidth/8)-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                  host_rvalid_o,
    output logic [NrHosts-1:0]                  host_err_o,
    output logic [NrHosts*DataWidth-1:0]        host_rdata_o,
    output logic [NrDevices-1:0]                device_req_o,
    output logic [NrDevices-1:0]                device_we_o,
    output logic [NrDevices*AddressWidth-1:0]   device_addr_o,
    output logic [NrDevices*DataWidth-1:0]      device_wdata_o,
    output logic [NrDevices*(DataWidth/8)-1:0]  device_be_o,
    input  logic [NrDevices-1:0]                device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]      device_rdata_i,
    input  logic [NrDevices*AddressWidth-1:0]   cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0]   cfg_device_addr_mask_i
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [HostIdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                    pend_q, pend_d;
    logic                    miss_q, miss_d;
    logic [HostIdxW-1:0]     host_idx_q, host_idx_d;
    logic [DevIdxW-1:0]      dev_idx_q, dev_idx_d;

    logic                    gnt_valid;
    logic [HostIdxW-1:0]     gnt_idx;
    int unsigned             arb_pos;
    int unsigned             ptr_nxt;

    logic [AddressWidth-1:0] sel_addr;
    logic [DataWidth-1:0]    sel_wdata;
    logic [BeWidth-1:0]      sel_be;
    logic                    sel_we;

    logic                    hit;
    logic [DevIdxW-1:0]      hit_idx;
    logic [NrDevices-1:0]    dev_sel;

    logic                    rsp_rvalid;
    logic [DataWidth-1:0]    rsp_rdata;

    // Arbitration: walk search positions in priority order and take the first requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        host_gnt_o = '0;
        arb_pos    = 0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            if (ArbMode == 0) begin
                arb_pos = i;
            end else begin
                arb_pos = i + 32'(rr_ptr_q);
                if (arb_pos >= NrHosts) arb_pos = arb_pos - NrHosts;
            end
            for (int unsigned h = 0; h < NrHosts; h++) begin
                if (!gnt_valid && host_req_i[h] && (arb_pos == h)) begin
                    gnt_valid     = 1'b1;
                    gnt_idx       = HostIdxW'(h);
                    host_gnt_o[h] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_we    = 1'b0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (host_gnt_o[h]) begin
                sel_addr  = host_addr_i[h*AddressWidth +: AddressWidth];
                sel_wdata = host_wdata_i[h*DataWidth +: DataWidth];
                sel_be    = host_be_i[h*BeWidth +: BeWidth];
                sel_we    = host_we_i[h];
            end
        end
    end

    // Decode: lowest-index matching window wins when windows overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        dev_sel = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (gnt_valid && !hit &&
                ((sel_addr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]) ==
                 cfg_device_addr_base_i[d*AddressWidth +: AddressWidth])) begin
                hit        = 1'b1;
                hit_idx    = DevIdxW'(d);
                dev_sel[d] = 1'b1;
            end
        end
    end

    always_comb begin
        device_req_o   = dev_sel;
        device_we_o    = '0;
        device_addr_o  = '0;
        device_wdata_o = '0;
        device_be_o    = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (dev_sel[d]) begin
                device_we_o[d]                              = sel_we;
                device_addr_o[d*AddressWidth +: AddressWidth] = sel_addr;
                device_wdata_o[d*DataWidth +: DataWidth]    = sel_wdata;
                device_be_o[d*BeWidth +: BeWidth]           = sel_be;
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        pend_d     = gnt_valid;
        miss_d     = gnt_valid && !hit;
        host_idx_d = host_idx_q;
        dev_idx_d  = dev_idx_q;
        ptr_nxt    = 0;
        if (gnt_valid) begin
            ptr_nxt = 32'(gnt_idx) + 1;
            if (ptr_nxt >= NrHosts) ptr_nxt = 0;
            rr_ptr_d   = HostIdxW'(ptr_nxt);
            host_idx_d = gnt_idx;
            dev_idx_d  = hit_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            pend_q     <= 1'b0;
            miss_q     <= 1'b0;
            host_idx_q <= '0;
            dev_idx_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            pend_q     <= pend_d;
            miss_q     <= miss_d;
            host_idx_q <= host_idx_d;
            dev_idx_q  <= dev_idx_d;
        end
    end

    always_comb begin
        rsp_rvalid = 1'b0;
        rsp_rdata  = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (dev_idx_q == DevIdxW'(d)) begin
                rsp_rvalid = device_rvalid_i[d];
                rsp_rdata  = device_rdata_i[d*DataWidth +: DataWidth];
            end
        end
    end

    // Responses are masked while reset is asserted so a discarded transaction never leaks out.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (rst_ni && pend_q && (host_idx_q == HostIdxW'(h))) begin
                host_rvalid_o[h] = miss_q || rsp_rvalid;
                host_err_o[h]    = miss_q;
                if (!miss_q) host_rdata_o[h*DataWidth +: DataWidth] = rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus.sv
// Bench for rr_bus: vector table for arbitration/decode plus a response scoreboard,
// followed by hand-written reset, overlap and mid-transaction reset sequences.
module tb_rr_bus;

    localparam int NH = 2;
    localparam int ND = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NH-1:0]    host_req, host_gnt, host_gnt_fp;
    logic [NH*AW-1:0] host_addr;
    logic [NH-1:0]    host_we;
    logic [NH*BW-1:0] host_be;
    logic [NH*DW-1:0] host_wdata;
    logic [NH-1:0]    host_rvalid, host_err, host_rvalid_fp, host_err_fp;
    logic [NH*DW-1:0] host_rdata, host_rdata_fp;
    logic [ND-1:0]    device_req, device_we, device_req_fp, device_we_fp;
    logic [ND*AW-1:0] device_addr, device_addr_fp;
    logic [ND*DW-1:0] device_wdata, device_wdata_fp;
    logic [ND*BW-1:0] device_be, device_be_fp;
    logic [ND-1:0]    device_rvalid;
    logic [ND*DW-1:0] device_rdata;
    logic [ND*AW-1:0] cfg_base, cfg_mask;

    logic [DW-1:0] dev_rd [ND];
    initial begin
        dev_rd[0] = 32'h0000_1111;
        dev_rd[1] = 32'hDEAD_BEEF;
        dev_rd[2] = 32'h2222_2222;
        dev_rd[3] = 32'h3333_3333;
    end
    assign device_rdata = {dev_rd[3], dev_rd[2], dev_rd[1], dev_rd[0]};

    rr_bus #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .ArbMode(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_err_o(host_err), .host_rdata_o(host_rdata),
        .device_req_o(device_req), .device_we_o(device_we), .device_addr_o(device_addr),
        .device_wdata_o(device_wdata), .device_be_o(device_be),
        .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata),
        .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
    );

    rr_bus #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .ArbMode(0)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt_fp), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid_fp), .host_err_o(host_err_fp), .host_rdata_o(host_rdata_fp),
        .device_req_o(device_req_fp), .device_we_o(device_we_fp), .device_addr_o(device_addr_fp),
        .device_wdata_o(device_wdata_fp), .device_be_o(device_be_fp),
        .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata),
        .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic valid;
        int   host;
        int   dev;
        logic miss;
    } resp_t;
    resp_t sb[$];

    // Expected response for the transaction granted one cycle earlier, using the device
    // response currently driven by the bench.
    task automatic check_resp(input string tag);
        resp_t            r;
        logic [NH-1:0]    ev;
        logic [NH-1:0]    ee;
        logic [NH*DW-1:0] ed;
        r  = sb.pop_front();
        ev = '0;
        ee = '0;
        ed = '0;
        if (r.valid) begin
            if (r.miss) begin
                ev[r.host] = 1'b1;
                ee[r.host] = 1'b1;
            end else begin
                ev[r.host] = device_rvalid[r.dev];
                ed[r.host*DW +: DW] = dev_rd[r.dev];
            end
        end
        check($sformatf("%s_rvalid", tag), host_rvalid, ev);
        check($sformatf("%s_err", tag), host_err, ee);
        check($sformatf("%s_rdata", tag), host_rdata, ed);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  we;
        logic [3:0]  dev_rv;
        logic [1:0]  gnt;
        logic [3:0]  dreq;
    } vec_t;
    vec_t vecs[14];

    initial begin
        logic [NH-1:0]    exp_fp;
        logic [ND*AW-1:0] exp_addr;
        logic [ND*DW-1:0] exp_wdata;
        logic [ND*BW-1:0] exp_be;
        logic [ND-1:0]    exp_we;
        logic [31:0]      wd [NH];
        logic [BW-1:0]    be [NH];
        int               gh;
        int               ds;
        resp_t            r;

        // rr_ptr starts at 0 after reset; comments give the pointer after each vector.
        vecs[0]  = '{2'b11, 32'h1000_0010, 32'h2000_0000, 2'b00, 4'b0000, 2'b01, 4'b0010}; // ptr 1
        vecs[1]  = '{2'b11, 32'h1000_0010, 32'h2000_0000, 2'b00, 4'b0010, 2'b10, 4'b0100}; // ptr 0
        vecs[2]  = '{2'b11, 32'h1000_0010, 32'h2000_0000, 2'b00, 4'b0100, 2'b01, 4'b0010}; // ptr 1
        vecs[3]  = '{2'b11, 32'h1000_0010, 32'h2000_0000, 2'b00, 4'b0000, 2'b10, 4'b0100}; // ptr 0
        vecs[4]  = '{2'b00, 32'h1000_0010, 32'h2000_0000, 2'b00, 4'b1111, 2'b00, 4'b0000}; // ptr 0
        vecs[5]  = '{2'b10, 32'h0000_0000, 32'h8000_0000, 2'b10, 4'b1111, 2'b10, 4'b0000}; // ptr 0
        vecs[6]  = '{2'b00, 32'h0000_0000, 32'h8000_0000, 2'b00, 4'b0000, 2'b00, 4'b0000}; // ptr 0
        vecs[7]  = '{2'b01, 32'h3000_0004, 32'h8000_0000, 2'b01, 4'b0000, 2'b01, 4'b1000}; // ptr 1
        vecs[8]  = '{2'b01, 32'h0000_0008, 32'h8000_0000, 2'b00, 4'b1000, 2'b01, 4'b0001}; // ptr 1
        vecs[9]  = '{2'b11, 32'h0000_0008, 32'h8000_0000, 2'b00, 4'b0001, 2'b10, 4'b0000}; // ptr 0
        vecs[10] = '{2'b00, 32'h0000_0008, 32'h8000_0000, 2'b00, 4'b0000, 2'b00, 4'b0000}; // ptr 0
        vecs[11] = '{2'b11, 32'h0000_0008, 32'h3000_0000, 2'b10, 4'b0000, 2'b01, 4'b0001}; // ptr 1
        vecs[12] = '{2'b11, 32'h0000_0008, 32'h3000_0000, 2'b10, 4'b0001, 2'b10, 4'b1000}; // ptr 0
        vecs[13] = '{2'b00, 32'h0000_0008, 32'h3000_0000, 2'b00, 4'b1000, 2'b00, 4'b0000}; // ptr 0

        be[0] = 4'h3;
        be[1] = 4'hC;

        cfg_base = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
        cfg_mask = {4{32'hF000_0000}};
        rst_n         = 1'b0;
        host_req      = '0;
        host_addr     = '0;
        host_we       = '0;
        host_be       = '0;
        host_wdata    = '0;
        device_rvalid = '0;

        // Reset phase: grant/decode stay live, responses held at zero.
        @(negedge clk);
        @(negedge clk);
        host_req      = 2'b01;
        host_addr     = {32'h0, 32'h1000_0000};
        device_rvalid = 4'b1111;
        #1;
        check("rst_gnt", host_gnt, 2'b01);
        check("rst_dev_req", device_req, 4'b0010);
        check("rst_rvalid", host_rvalid, '0);
        check("rst_err", host_err, '0);
        check("rst_rdata", host_rdata, '0);

        @(negedge clk);
        rst_n    = 1'b1;
        host_req = '0;
        #1;
        check("post_rst_rvalid", host_rvalid, '0);
        check("post_rst_err", host_err, '0);
        check("post_rst_rdata", host_rdata, '0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            wd[0]         = 32'hA0A0_0000 + 32'(i);
            wd[1]         = 32'hB1B1_0000 + 32'(i);
            host_req      = vecs[i].req;
            host_addr     = {vecs[i].a1, vecs[i].a0};
            host_we       = vecs[i].we;
            host_wdata    = {wd[1], wd[0]};
            host_be       = {be[1], be[0]};
            device_rvalid = vecs[i].dev_rv;
            #1;
            if (sb.size() > 0) check_resp($sformatf("v%0d_rsp", i));

            check($sformatf("v%0d_gnt", i), host_gnt, vecs[i].gnt);
            exp_fp = vecs[i].req[0] ? 2'b01 : (vecs[i].req[1] ? 2'b10 : 2'b00);
            check($sformatf("v%0d_gnt_fixed", i), host_gnt_fp, exp_fp);
            check($sformatf("v%0d_dev_req", i), device_req, vecs[i].dreq);

            gh = vecs[i].gnt[1] ? 1 : 0;
            ds = 0;
            for (int d = 0; d < ND; d++) if (vecs[i].dreq[d]) ds = d;
            exp_addr  = '0;
            exp_wdata = '0;
            exp_be    = '0;
            exp_we    = '0;
            if (vecs[i].dreq != 4'b0000) begin
                exp_addr[ds*AW +: AW]  = gh ? vecs[i].a1 : vecs[i].a0;
                exp_wdata[ds*DW +: DW] = wd[gh];
                exp_be[ds*BW +: BW]    = be[gh];
                exp_we[ds]             = vecs[i].we[gh];
            end
            check($sformatf("v%0d_dev_addr", i), device_addr, exp_addr);
            check($sformatf("v%0d_dev_wdata", i), device_wdata, exp_wdata);
            check($sformatf("v%0d_dev_be", i), device_be, exp_be);
            check($sformatf("v%0d_dev_we", i), device_we, exp_we);

            r.valid = (vecs[i].gnt != 2'b00);
            r.host  = gh;
            r.dev   = ds;
            r.miss  = (vecs[i].dreq == 4'b0000);
            sb.push_back(r);
        end

        @(negedge clk);
        host_req      = '0;
        device_rvalid = '0;
        #1;
        check_resp("tail_rsp");

        // Overlapping windows: device 0 wins, device 1 stays idle. rr_ptr is 0 here.
        @(negedge clk);
        cfg_base  = {32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
        cfg_mask  = {32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'h0000_0000};
        host_req  = 2'b01;
        host_addr = {32'h0, 32'h7777_0000};
        #1;
        check("ovl_gnt", host_gnt, 2'b01);
        check("ovl_dev_req", device_req, 4'b0001);
        @(negedge clk);
        host_req      = '0;
        device_rvalid = 4'b0001;
        #1;
        check("ovl_rvalid", host_rvalid, 2'b01);
        check("ovl_rdata", host_rdata, {32'h0, 32'h0000_1111});
        cfg_base = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
        cfg_mask = {4{32'hF000_0000}};

        // Mid-transaction reset: rr_ptr is 1, host 0 granted to device 1, then reset.
        @(negedge clk);
        host_req      = 2'b01;
        host_addr     = {32'h2000_0000, 32'h1000_0000};
        device_rvalid = '0;
        #1;
        check("mtr_gnt", host_gnt, 2'b01);
        check("mtr_dev_req", device_req, 4'b0010);
        @(negedge clk);
        rst_n         = 1'b0;
        host_req      = '0;
        device_rvalid = 4'b1111;
        #1;
        check("mtr_rvalid_in_rst", host_rvalid, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mtr_rvalid_after", host_rvalid, '0);
        check("mtr_err_after", host_err, '0);
        host_req = 2'b11;
        #1;
        check("mtr_ptr_reset_gnt", host_gnt, 2'b01);
        check("mtr_dev_req2", device_req, 4'b0010);
        @(negedge clk);
        host_req = '0;
        #1;
        check("mtr_post_rvalid", host_rvalid, 2'b01);
        check("mtr_post_rdata", host_rdata, {32'h0, 32'hDEAD_BEEF});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_bus.md
RR_BUS -- requirements
Module: rr_bus

Interface
REQ-001 Parameter NrHosts, default 2: number of host ports, 1..16.
REQ-002 Parameter NrDevices, default 4: number of device ports, 1..16.
REQ-003 Parameter DataWidth, default 32: data width, multiple of 8.
REQ-004 Parameter AddressWidth, default 32: address width.
REQ-005 Parameter ArbMode, default 1: 0 = fixed priority (lowest host index wins), 1 = round-robin.
REQ-006 clk_i  in  1  single clock, all state updates on rising edge.
REQ-007 rst_ni  in  1  synchronous, active-low reset.
REQ-008 host_req_i  in  NrHosts  per-host request.
REQ-009 host_gnt_o  out  NrHosts  per-host grant, one-hot or zero.
REQ-010 host_addr_i / host_wdata_i  in  NrHosts*AddressWidth / NrHosts*DataWidth  flattened, host h at slice h.
REQ-011 host_we_i / host_be_i  in  NrHosts / NrHosts*(DataWidth/8)  write enable, byte enables.
REQ-012 host_rvalid_o / host_err_o  out  NrHosts  response valid, error flag.
REQ-013 host_rdata_o  out  NrHosts*DataWidth  response data.
REQ-014 device_req_o / device_we_o  out  NrDevices  per-device request, write enable.
REQ-015 device_addr_o / device_wdata_o / device_be_o  out  flattened per device  forwarded request fields.
REQ-016 device_rvalid_i / device_rdata_i  in  NrDevices / NrDevices*DataWidth  device response.
REQ-017 cfg_device_addr_base_i / cfg_device_addr_mask_i  in  NrDevices*AddressWidth  address map.

Function
REQ-018 Arbitration combinational: grant issued same cycle as request; at most one host granted per cycle.
REQ-019 ArbMode 0: lowest-index requesting host granted.
REQ-020 ArbMode 1: search starts at rr_ptr, ascending with wrap at NrHosts-1 -> 0; first requester granted.
REQ-021 rr_ptr updates only on a grant, to (granted+1) mod NrHosts; unchanged in idle cycles.
REQ-022 Device decode: device d hit when (addr & mask[d]) == base[d]; lowest-index hit wins on overlap.
REQ-023 Hit: only hit device sees req=1 and granted host's addr/we/be/wdata; all other device outputs zero.
REQ-024 Miss (no hit): no device_req_o asserted; grant still issued.
REQ-025 Response register on grant: captures host index, device index, miss flag, pend=1; otherwise pend=0.
REQ-026 Latency exactly 1 cycle: cycle after grant, host_rvalid_o[h] = device_rvalid_i[dev] (hit) or 1 (miss).
REQ-027 Miss response: host_err_o[h]=1, host_rdata_o[h]=0; hit response: err=0, rdata = device_rdata_i[dev].
REQ-028 Hit whose device_rvalid_i is 0 in the response cycle: host_rvalid_o=0, err=0; transaction complete, no retry.
REQ-029 Non-responding hosts: rvalid=0, err=0, rdata=0 every cycle.
REQ-030 Back-to-back grants every cycle allowed; response of grant N coincides with grant N+1.
REQ-031 Request fields held stable by host only while req=1 and gnt=0; bus has no request buffering.

Reset
REQ-032 rst_ni=0 at rising edge: rr_ptr=0, pend=0, captured indices=0, miss=0.
REQ-033 During and first cycle after reset: all host_rvalid_o, host_err_o, host_rdata_o = 0.
REQ-034 Reset mid-transaction: pending response discarded, never delivered.
REQ-035 Grant/device outputs combinational; they follow inputs even while rst_ni=0.

Verification
REQ-036 ArbMode 1, NrHosts=2, both req held 4 cycles -> gnt 01,10,01,10; rr_ptr 1,0,1,0.
REQ-037 ArbMode 0, same stimulus -> gnt 01 all 4 cycles; host 1 never granted.
REQ-038 base0=0x0000_0000 mask0=0xF000_0000, base1=0x1000_0000 mask1=0xF000_0000; host0 read 0x1000_0010, device1 rvalid=1 rdata=0xDEAD_BEEF next cycle -> device_req_o=0010, host_rvalid_o[0]=1, rdata=0xDEAD_BEEF, err=0.
REQ-039 Host 1 write 0x8000_0000 (unmapped) -> device_req_o=0, gnt[1]=1; next cycle rvalid[1]=1, err[1]=1, rdata=0.
REQ-040 Grant host0 to device1, rst_ni=0 next edge -> host_rvalid_o=0 following cycle; rr_ptr=0.
REQ-041 Overlap: base0=base1=0, masks 0 -> device0 selected, device1 idle.
